// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and receiver.
//   rx_state_e : receiver FSM state encoding (3-bit)
//   bit_div()  : clocks per bit, rounded to nearest
//   half_div() : clocks per half bit (mid-bit sample offset)
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Rounding rule shared by both directions so that tx and rx agree on bit length.
  function automatic int bit_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int half_div(input int clk_hz, input int baud);
    return bit_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an asynchronous level input.
//   clk_i   : sampling clock
//   rst_i   : synchronous active-high reset, both flops load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronised output (second flop)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver, mid-bit sampling, LSB first.
//   clk12     : system clock
//   rst       : synchronous active-high reset; aborts any frame in progress
//   rx        : asynchronous serial line, idle high
//   rbyte     : last correctly framed byte, held until the next good byte
//   rbyte_rdy : one-cycle pulse when rbyte is updated
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : high whenever the receiver is not idle
//
// state      | meaning
// ST_IDLE    | line idle, waiting for a low level
// ST_START   | half a bit in, confirming the start bit
// ST_DATA    | sampling 8 data bits, one per bit period
// ST_STOP    | sampling the stop bit
// ST_WAIT_HIGH | framing error seen, waiting for the line to go high
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk12,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rbyte,
  output logic       rbyte_rdy,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
  localparam int HALF    = half_div(CLK_HZ, BAUD);
  localparam int CW      = $clog2(BIT_DIV);

  // Down-counter reload values: a sample fires when the counter reaches zero.
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF - 1);

  logic rx_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk12),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rbyte_q, rbyte_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;
  logic          tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    rbyte_d = rbyte_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_RELOAD;
          idx_d   = 3'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = BIT_RELOAD;
          end else begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_RELOAD;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (rx_s) begin
            rbyte_d = shift_q;
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low break must not look like a stream of start bits.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk12) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      rbyte_q <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rbyte_q <= rbyte_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rbyte     = rbyte_q;
  assign rbyte_rdy = rdy_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int BIT_DIV  = 104;
  localparam int HALF     = 52;
  localparam int PULSE_AT = HALF + 9 * BIT_DIV;   // 988 edges after t0
  localparam int NOM_MC   = 104000;               // bit period in milli-cycles

  logic       clk12 = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rbyte;
  logic       rbyte_rdy;
  logic       frame_err;
  logic       busy;

  serial_rx #(.CLK_HZ(12_000_000), .BAUD(115200)) dut (
    .clk12     (clk12),
    .rst       (rst),
    .rx        (rx),
    .rbyte     (rbyte),
    .rbyte_rdy (rbyte_rdy),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk12 = ~clk12;

  int ecnt = 0;
  always @(posedge clk12) ecnt++;

  logic [7:0] rdy_bytes[$];
  int         rdy_edges[$];
  logic       rdy_busy[$];
  int         ferr_edges[$];
  int         both_cnt = 0;

  // Outputs sampled on the falling edge; ecnt then names the rising edge
  // that produced the value.
  always @(negedge clk12) begin
    if (rbyte_rdy) begin
      rdy_bytes.push_back(rbyte);
      rdy_edges.push_back(ecnt);
      rdy_busy.push_back(busy);
    end
    if (frame_err) ferr_edges.push_back(ecnt);
    if (rbyte_rdy && frame_err) both_cnt++;
  end

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] model_rbyte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int e);
    while (ecnt < e) @(negedge clk12);
  endtask

  task automatic clear_events();
    rdy_bytes.delete();
    rdy_edges.delete();
    rdy_busy.delete();
    ferr_edges.delete();
  endtask

  // Drives one frame from a falling edge. per_mc is the bit period in
  // milli-cycles so off-nominal baud rates keep their fractional timing.
  // abort_bit >= 0 pulses rst mid-way through that frame bit and releases
  // the line. t0 is the edge at which the receiver first sees the start bit
  // (two synchroniser flops plus one FSM edge after the drive).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int per_mc,
                            input int abort_bit, output int t0);
    int n;
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    n  = ecnt;
    t0 = n + 3;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == abort_bit) begin
        wait_until(n + (i * per_mc + per_mc / 2 + 500) / 1000);
        rst = 1'b1;
        @(negedge clk12);
        rst = 1'b0;
        rx  = 1'b1;
        return;
      end
      wait_until(n + ((i + 1) * per_mc + 500) / 1000);
    end
  endtask

  // Frame-level model: a good stop bit yields exactly one byte pulse carrying
  // the byte, a bad one exactly one error pulse and no change to rbyte.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic stop_v,
                             input int t0, input logic chk_time);
    int ev_edge;
    if (stop_v) model_rbyte = b;
    check({tag, " rdy_count"},  rdy_bytes.size(),  stop_v ? 1 : 0);
    check({tag, " ferr_count"}, ferr_edges.size(), stop_v ? 0 : 1);
    if (stop_v && rdy_bytes.size() > 0)
      check({tag, " byte"}, rdy_bytes[0], b);
    if (chk_time) begin
      if (stop_v) ev_edge = (rdy_edges.size()  > 0) ? rdy_edges[0]  : -1;
      else        ev_edge = (ferr_edges.size() > 0) ? ferr_edges[0] : -1;
      check({tag, " pulse_edge"}, ev_edge, t0 + PULSE_AT);
    end
    check({tag, " rbyte"}, rbyte, model_rbyte);
  endtask

  initial begin
    int t0, t0b, n, gap, hold;
    logic [7:0] b;
    logic sv;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk12);
    rst = 1'b0;
    @(negedge clk12);
    model_rbyte = 8'h00;

    check("reset rbyte", rbyte, 8'h00);
    check("reset rdy",   rbyte_rdy, 1'b0);
    check("reset ferr",  frame_err, 1'b0);
    check("reset busy",  busy, 1'b0);
    repeat (5) @(negedge clk12);

    // 1: nominal frame, pulse timing, busy low alongside the pulse
    clear_events();
    send_frame(8'hA5, 1'b1, NOM_MC, -1, t0);
    check_frame("t1", 8'hA5, 1'b1, t0, 1'b1);
    if (rdy_busy.size() > 0) check("t1 busy_at_pulse", rdy_busy[0], 1'b0);
    repeat (20) @(negedge clk12);

    // 2: 20-cycle glitch is rejected at the half-bit check
    clear_events();
    n  = ecnt;
    t0 = n + 3;
    rx = 1'b0;
    wait_until(n + 20);
    rx = 1'b1;
    wait_until(t0 + HALF - 1);
    check("t2 busy_before", busy, 1'b1);
    wait_until(t0 + HALF);
    check("t2 busy_drop", busy, 1'b0);
    repeat (50) @(negedge clk12);
    check("t2 rdy_count",  rdy_bytes.size(), 0);
    check("t2 ferr_count", ferr_edges.size(), 0);
    check("t2 rbyte", rbyte, model_rbyte);

    // 3: low stop bit followed by a 500-cycle break
    clear_events();
    send_frame(8'h3C, 1'b0, NOM_MC, -1, t0);
    repeat (500) @(negedge clk12);
    check_frame("t3", 8'h3C, 1'b0, t0, 1'b1);
    check("t3 busy_in_break", busy, 1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk12);
    check("t3 busy_release", busy, 1'b0);
    repeat (10) @(negedge clk12);

    // 4: back-to-back frames with no idle gap
    clear_events();
    send_frame(8'h00, 1'b1, NOM_MC, -1, t0);
    send_frame(8'hFF, 1'b1, NOM_MC, -1, t0b);
    check("t4 rdy_count", rdy_bytes.size(), 2);
    if (rdy_bytes.size() == 2) begin
      check("t4 byte0", rdy_bytes[0], 8'h00);
      check("t4 byte1", rdy_bytes[1], 8'hFF);
      check("t4 spacing", rdy_edges[1] - rdy_edges[0], 10 * BIT_DIV);
      check("t4 edge0", rdy_edges[0], t0 + PULSE_AT);
    end
    model_rbyte = 8'hFF;
    check("t4 ferr_count", ferr_edges.size(), 0);
    repeat (10) @(negedge clk12);

    // 5: reset during data bit 4 (frame bit 5), then a clean frame
    clear_events();
    send_frame(8'h5A, 1'b1, NOM_MC, 5, t0);
    model_rbyte = 8'h00;
    check("t5 busy_after_rst", busy, 1'b0);
    repeat (1100) @(negedge clk12);
    check("t5 rdy_count_abort", rdy_bytes.size(), 0);
    check("t5 ferr_count_abort", ferr_edges.size(), 0);
    check("t5 rbyte_zero", rbyte, 8'h00);
    clear_events();
    send_frame(8'h81, 1'b1, NOM_MC, -1, t0);
    check_frame("t5", 8'h81, 1'b1, t0, 1'b1);
    repeat (10) @(negedge clk12);

    // 6: +/-2 % baud mismatch (117500 and 112900 baud)
    clear_events();
    send_frame(8'h96, 1'b1, 102128, -1, t0);
    repeat (10) @(negedge clk12);
    check_frame("t6 fast", 8'h96, 1'b1, t0, 1'b0);
    clear_events();
    send_frame(8'h96, 1'b1, 106289, -1, t0);
    repeat (10) @(negedge clk12);
    check_frame("t6 slow", 8'h96, 1'b1, t0, 1'b0);

    // Randomized frames: random data, occasional bad stop bits, random gaps
    for (int k = 0; k < 16; k++) begin
      b   = 8'($urandom_range(0, 255));
      sv  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 30);
      clear_events();
      send_frame(b, sv, NOM_MC, -1, t0);
      check_frame($sformatf("rnd%0d", k), b, sv, t0, 1'b1);
      if (!sv) begin
        hold = $urandom_range(0, 200);
        repeat (hold) @(negedge clk12);
        check($sformatf("rnd%0d busy_break", k), busy, 1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk12);
        check($sformatf("rnd%0d busy_release", k), busy, 1'b0);
      end
      repeat (gap) @(negedge clk12);
    end

    check("rdy_ferr_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
